// File: rtl/rf_write_scheduler.sv
// Write-port scheduler for the register file: after reset or init_req it clears R0..R(NREG-1),
// then shares we3/a3/wd3 round-robin between ALU (req0) and load (req1) writeback.
//
// state | meaning
// INIT  | clearing R[idx] to zero, one register per cycle; requesters stalled
// RUN   | arbitrating requesters, one accepted write per cycle
module rf_write_scheduler #(
    parameter int N    = 4,
    parameter int M    = 32,
    parameter int NREG = 15
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         init_req,
    input  logic         req0_valid,
    input  logic [N-1:0] req0_addr,
    input  logic [M-1:0] req0_data,
    output logic         req0_ready,
    input  logic         req1_valid,
    input  logic [N-1:0] req1_addr,
    input  logic [M-1:0] req1_data,
    output logic         req1_ready,
    output logic         we3,
    output logic [N-1:0] a3,
    output logic [M-1:0] wd3,
    output logic         busy,
    output logic         err_r15,
    output logic [15:0]  wr_count
);

    typedef enum logic {INIT, RUN} state_t;

    localparam logic [N-1:0] IDX_LAST = N'(NREG - 1);
    localparam logic [N-1:0] IDX_ONE  = N'(1);
    localparam logic [N-1:0] PC_ADDR  = N'(15);

    state_t         state, state_next;
    logic [N-1:0]   idx, idx_next;
    logic           rr_last;
    logic           accept;
    logic           grant_sel;
    logic [N-1:0]   gnt_addr;
    logic [M-1:0]   gnt_data;
    logic           hit_r15;

    always_comb begin
        state_next = state;
        idx_next   = idx;
        accept     = 1'b0;
        grant_sel  = 1'b0;
        case (state)
            INIT: begin
                if (idx == IDX_LAST) begin
                    state_next = RUN;
                    idx_next   = '0;
                end else begin
                    idx_next = idx + IDX_ONE;
                end
            end
            RUN: begin
                if (init_req) begin
                    state_next = INIT;
                    idx_next   = '0;
                end else if (req0_valid && req1_valid) begin
                    // rr_last==1 means req1 was served last, so req0 wins the tie
                    grant_sel = ~rr_last;
                    accept    = 1'b1;
                end else if (req0_valid) begin
                    accept = 1'b1;
                end else if (req1_valid) begin
                    grant_sel = 1'b1;
                    accept    = 1'b1;
                end
            end
            default: state_next = INIT;
        endcase
        req0_ready = accept & ~grant_sel;
        req1_ready = accept & grant_sel;
        gnt_addr   = grant_sel ? req1_addr : req0_addr;
        gnt_data   = grant_sel ? req1_data : req0_data;
        hit_r15    = (gnt_addr == PC_ADDR);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= INIT;
            idx      <= '0;
            rr_last  <= 1'b1;
            we3      <= 1'b0;
            a3       <= '0;
            wd3      <= '0;
            err_r15  <= 1'b0;
            wr_count <= '0;
        end else begin
            state   <= state_next;
            idx     <= idx_next;
            we3     <= 1'b0;
            err_r15 <= 1'b0;
            if (state == INIT) begin
                we3 <= 1'b1;
                a3  <= idx;
                wd3 <= '0;
            end else if (accept) begin
                rr_last <= grant_sel;
                // R15 is the PC and is never written through this port
                if (hit_r15) begin
                    err_r15 <= 1'b1;
                end else begin
                    we3 <= 1'b1;
                    a3  <= gnt_addr;
                    wd3 <= gnt_data;
                    if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
                end
            end
        end
    end

    assign busy = (state == INIT);

endmodule

// File: tb/tb_rf_write_scheduler.sv
// Directed bench for rf_write_scheduler: a reference model pushes the expected write-port
// contents for the next cycle into a queue; each cycle pops and compares against the DUT.
module tb_rf_write_scheduler;

    logic        clk = 1'b0;
    logic        reset, init_req;
    logic        r0v, r1v, r0r, r1r;
    logic [3:0]  r0a, r1a, a3;
    logic [31:0] r0d, r1d, wd3;
    logic        we3, busy, err_r15;
    logic [15:0] wr_count;

    rf_write_scheduler dut (
        .clk(clk), .reset(reset), .init_req(init_req),
        .req0_valid(r0v), .req0_addr(r0a), .req0_data(r0d), .req0_ready(r0r),
        .req1_valid(r1v), .req1_addr(r1a), .req1_data(r1d), .req1_ready(r1r),
        .we3(we3), .a3(a3), .wd3(wd3), .busy(busy), .err_r15(err_r15), .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic        err;
        logic        chk;
        logic [3:0]  a;
        logic [31:0] d;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_err = 0;

    logic m_init;
    int   m_idx;
    logic m_rr;
    int   m_cnt;
    logic m_acc0;
    int   busy_cnt;
    int   obs_seq;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic we, input logic err, input logic c, input logic [3:0] a,
                        input logic [31:0] d);
        exp_t e;
        e.we = we; e.err = err; e.chk = c; e.a = a; e.d = d;
        sbq.push_back(e);
    endtask

    task automatic model_reset();
        m_init = 1'b1;
        m_idx  = 0;
        m_rr   = 1'b1;
        m_cnt  = 0;
        sbq.delete();
        push(1'b0, 1'b0, 1'b1, 4'd0, 32'd0);
    endtask

    // One clock cycle: check at the negedge, then advance the model at the posedge.
    task automatic step();
        logic        acc, gs;
        logic [3:0]  ga;
        logic [31:0] gd;
        exp_t        e;
        @(negedge clk);
        acc = 1'b0;
        gs  = 1'b0;
        if (!m_init && !init_req) begin
            if (r0v && r1v) begin gs = ~m_rr; acc = 1'b1; end
            else if (r0v)   begin gs = 1'b0;  acc = 1'b1; end
            else if (r1v)   begin gs = 1'b1;  acc = 1'b1; end
        end
        ga = gs ? r1a : r0a;
        gd = gs ? r1d : r0d;
        chk("req0_ready", 32'(r0r), 32'(acc & ~gs));
        chk("req1_ready", 32'(r1r), 32'(acc & gs));
        chk("busy", 32'(busy), 32'(m_init));
        chk("wr_count", 32'(wr_count), 32'(m_cnt));
        if (busy === 1'b1) busy_cnt++;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("we3", 32'(we3), 32'(e.we));
            chk("err_r15", 32'(err_r15), 32'(e.err));
            if (e.chk) begin
                chk("a3", 32'(a3), 32'(e.a));
                chk("wd3", wd3, e.d);
            end
        end
        if (we3 === 1'b1 && wd3[31:16] === 16'h5A5A) begin
            chk("stream_order", 32'(wd3[15:0]), 32'(obs_seq));
            obs_seq++;
        end
        @(posedge clk);
        #1;
        m_acc0 = 1'b0;
        if (!reset) begin
            model_reset();
        end else if (m_init) begin
            push(1'b1, 1'b0, 1'b1, m_idx[3:0], 32'd0);
            if (m_idx == 14) begin m_init = 1'b0; m_idx = 0; end
            else m_idx++;
        end else if (init_req) begin
            push(1'b0, 1'b0, 1'b0, 4'd0, 32'd0);
            m_init = 1'b1;
            m_idx  = 0;
        end else if (acc) begin
            m_rr   = gs;
            m_acc0 = ~gs;
            if (ga == 4'd15) begin
                push(1'b0, 1'b1, 1'b0, 4'd0, 32'd0);
            end else begin
                push(1'b1, 1'b0, 1'b1, ga, gd);
                if (m_cnt != 16'hFFFF) m_cnt++;
            end
        end else begin
            push(1'b0, 1'b0, 1'b0, 4'd0, 32'd0);
        end
    endtask

    task automatic idle_inputs();
        init_req = 1'b0;
        r0v = 1'b0; r0a = 4'd0; r0d = 32'd0;
        r1v = 1'b0; r1a = 4'd0; r1d = 32'd0;
    endtask

    initial begin
        int seq;
        reset = 1'b0;
        idle_inputs();
        obs_seq = 0;
        busy_cnt = 0;
        seq = 0;
        m_acc0 = 1'b0;

        // Reset held for 3 edges, then the 15-write clear with requesters stalled
        @(posedge clk);
        #1;
        model_reset();
        repeat (2) step();
        reset = 1'b1;
        r0v = 1'b1; r0a = 4'd1; r0d = 32'hA;
        r1v = 1'b1; r1a = 4'd2; r1d = 32'hB;
        busy_cnt = 0;
        repeat (15) step();
        chk("t1_busy_cycles", 32'(busy_cnt), 32'd15);

        // Both requesters valid for 4 cycles: round-robin starting with req0
        repeat (4) step();
        idle_inputs();
        step();
        chk("t3_wr_count", 32'(wr_count), 32'd4);

        // Single req0 write
        r0v = 1'b1; r0a = 4'd3; r0d = 32'h0F0F0F0F;
        step();
        idle_inputs();
        step();
        chk("t2_wr_count", 32'(wr_count), 32'd5);

        // Write to R15 is rejected and flagged
        r1v = 1'b1; r1a = 4'd15; r1d = 32'hFFFFFFFF;
        step();
        idle_inputs();
        step();
        step();
        chk("t4_wr_count", 32'(wr_count), 32'd5);

        // req0 streaming with a one-cycle init_req in the middle
        busy_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            r0v = 1'b1;
            r0a = 4'(seq % 8 + 1);
            r0d = 32'h5A5A0000 | 32'(seq);
            init_req = (i == 3);
            step();
            if (m_acc0) seq++;
        end
        idle_inputs();
        repeat (2) step();
        chk("t5_busy_cycles", 32'(busy_cnt), 32'd15);
        chk("t5_stream_count", 32'(obs_seq), 32'(seq));

        // Reset in the middle of a clear restarts it from R0
        reset = 1'b0;
        step();
        reset = 1'b1;
        repeat (7) step();
        chk("t6_idx_before_reset", 32'(m_idx), 32'd7);
        reset = 1'b0;
        step();
        reset = 1'b1;
        r0v = 1'b1; r0a = 4'd6; r0d = 32'h66;
        r1v = 1'b1; r1a = 4'd7; r1d = 32'h77;
        busy_cnt = 0;
        repeat (15) step();
        chk("t6_busy_cycles", 32'(busy_cnt), 32'd15);
        repeat (3) step();
        idle_inputs();
        repeat (2) step();
        chk("t6_wr_count", 32'(wr_count), 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
